// File: rtl/led_seq_pkg.sv
// Shared types, mode codes and the LED frame lookup for the LED bank sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;

    localparam logic [1:0] MODE_WALK   = 2'd0;
    localparam logic [1:0] MODE_DOUBLE = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    // Frame index is the step count; shorter patterns wrap on its low bits.
    function automatic logic [3:0] frame_pattern(input logic [1:0] mode, input logic [3:0] idx);
        logic [3:0] pat;
        pat = 4'b0000;
        case (mode)
            MODE_WALK:   pat = 4'b0001 << idx[1:0];
            MODE_DOUBLE: begin
                case (idx[1:0])
                    2'd0:    pat = 4'b1100;
                    2'd1:    pat = 4'b1001;
                    2'd2:    pat = 4'b0011;
                    default: pat = 4'b0110;
                endcase
            end
            MODE_BLINK:  pat = idx[0] ? 4'b0000 : 4'b1111;
            default:     pat = idx;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_seq_arbiter_step_tick.sv
// Step prescaler: counts 0..STEP_DIV-1 while enabled, tick on the last count.
module led_step_tick #(
    parameter int STEP_DIV = 24_000_000,
    parameter int CNT_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = !clr && (cnt_reg == LAST);

endmodule

// File: rtl/led_seq_arbiter.sv
// Round-robin owner of the 4-lamp LED bank; plays the granted pattern for len steps.
module led_seq_arbiter
    import led_seq_pkg::*;
#(
    parameter int STEP_DIV = 24_000_000,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [1:0] mode0,
    input  logic [3:0] len0,
    input  logic       req1,
    input  logic [1:0] mode1,
    input  logic [3:0] len1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic [3:0] led
);

    state_t     state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       ptr_reg,   ptr_next;
    logic [1:0] mode_reg,  mode_next;
    logic [4:0] len_reg,   len_next;
    logic [4:0] step_reg,  step_next;

    logic [NUM_REQ-1:0] req_vec;
    logic [1:0]         mode_arr [NUM_REQ];
    logic [3:0]         len_arr  [NUM_REQ];
    logic               grant_idx;
    logic               tick;

    assign req_vec     = {req1, req0};
    assign mode_arr[0] = mode0;
    assign mode_arr[1] = mode1;
    assign len_arr[0]  = len0;
    assign len_arr[1]  = len1;

    led_step_tick #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W)
    ) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_reg != RUN),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            ptr_reg   <= 1'b1;
            mode_reg  <= 2'd0;
            len_reg   <= 5'd0;
            step_reg  <= 5'd0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            mode_reg  <= mode_next;
            len_reg   <= len_next;
            step_reg  <= step_next;
        end
    end

    // On a tie the requester that did not own the bank last time wins.
    always_comb begin
        grant_idx = (req_vec == 2'b11) ? ~ptr_reg : req_vec[1];
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        mode_next  = mode_reg;
        len_next   = len_reg;
        step_next  = step_reg;
        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    state_next = RUN;
                    owner_next = grant_idx;
                    ptr_next   = grant_idx;
                    mode_next  = mode_arr[grant_idx];
                    len_next   = (len_arr[grant_idx] == 4'd0) ? 5'd16 : {1'b0, len_arr[grant_idx]};
                    step_next  = 5'd0;
                end
            end
            RUN: begin
                if (!req_vec[owner_reg]) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (step_reg + 5'd1 == len_reg) begin
                        state_next = DONE;
                    end else begin
                        step_next = step_reg + 5'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
        led  = (state_reg == RUN) ? frame_pattern(mode_reg, step_reg[3:0]) : 4'b0000;
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = (state_reg == RUN) && (owner_reg == 1'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_led_seq_arbiter.sv
// Directed bench for led_seq_arbiter with a short step period.
module tb_led_seq_arbiter;

    localparam int STEP_DIV = 4;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [1:0] mode0, mode1;
    logic [3:0] len0, len1;
    logic [1:0] gnt;
    logic       busy, done;
    logic [3:0] led;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       req0;
        logic [1:0] mode0;
        logic [3:0] len0;
        logic       req1;
        logic [1:0] mode1;
        logic [3:0] len1;
        logic [1:0] gnt;
        logic       busy;
        logic       done;
        logic [3:0] led;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];

    led_seq_arbiter #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .mode0 (mode0),
        .len0  (len0),
        .req1  (req1),
        .mode1 (mode1),
        .len1  (len1),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(input logic r, input logic q0, input logic [1:0] m0, input logic [3:0] l0,
                                    input logic q1, input logic [1:0] m1, input logic [3:0] l1,
                                    input logic [1:0] g, input logic b, input logic d, input logic [3:0] l);
        vec_t v;
        v.rst = r;  v.req0 = q0; v.mode0 = m0; v.len0 = l0;
        v.req1 = q1; v.mode1 = m1; v.len1 = l1;
        v.gnt = g;  v.busy = b;  v.done = d;  v.led = l;
        vecs.push_back(v);
    endfunction

    task automatic cycle(input string name, input logic [1:0] eg, input logic eb, input logic ed, input logic [3:0] el);
        @(posedge clk);
        #1;
        checks++;
        if ({gnt, busy, done, led} !== {eg, eb, ed, el}) begin
            failures++;
            $display("FAIL %s: got gnt=%b busy=%b done=%b led=%b, required gnt=%b busy=%b done=%b led=%b",
                     name, gnt, busy, done, led, eg, eb, ed, el);
        end else begin
            $display("ok   %s: gnt=%b busy=%b done=%b led=%b", name, gnt, busy, done, led);
        end
    endtask

    // Each queued frame is expected for STEP_DIV consecutive cycles.
    task automatic play(input string name, input logic [1:0] g);
        int n;
        n = exp_q.size();
        for (int f = 0; f < n; f++) begin
            logic [3:0] fr;
            fr = exp_q.pop_front();
            for (int k = 0; k < STEP_DIV; k++) begin
                cycle($sformatf("%s f%0d c%0d", name, f, k), g, 1'b1, 1'b0, fr);
            end
        end
    endtask

    initial begin
        logic [3:0] dbl [4];
        dbl[0] = 4'b1100; dbl[1] = 4'b1001; dbl[2] = 4'b0011; dbl[3] = 4'b0110;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        mode0 = 2'd0; mode1 = 2'd0; len0 = 4'd0; len1 = 4'd0;

        // Reset with req0 pending, then a len 4 double walk; mode/len changes mid-run ignored.
        for (int i = 0; i < 3; i++) add_vec(1, 1, 1, 4, 0, 0, 0, 2'b00, 0, 0, 4'b0000);
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < STEP_DIV; k++) begin
                if (f == 0) add_vec(0, 1, 1, 4, 0, 0, 0, 2'b01, 1, 0, dbl[f]);
                else        add_vec(0, 1, 3, 1, 0, 0, 0, 2'b01, 1, 0, dbl[f]);
            end
        end
        add_vec(0, 1, 1, 4, 0, 0, 0, 2'b00, 1, 1, 4'b0000);
        add_vec(0, 0, 1, 4, 0, 0, 0, 2'b00, 0, 0, 4'b0000);
        add_vec(0, 0, 1, 4, 0, 0, 0, 2'b00, 0, 0, 4'b0000);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req0 = vecs[i].req0; mode0 = vecs[i].mode0; len0 = vecs[i].len0;
            req1 = vecs[i].req1; mode1 = vecs[i].mode1; len1 = vecs[i].len1;
            cycle($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].done, vecs[i].led);
        end

        // Both requesters held: alternate ownership with one IDLE cycle between runs.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        mode0 = 2'd0; len0 = 4'd2; mode1 = 2'd2; len1 = 4'd3;
        cycle("rr reset", 2'b00, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        exp_q = '{4'b0001, 4'b0010};
        play("rr req0", 2'b01);
        cycle("rr done0", 2'b00, 1'b1, 1'b1, 4'b0000);
        cycle("rr idle0", 2'b00, 1'b0, 1'b0, 4'b0000);
        exp_q = '{4'b1111, 4'b0000, 4'b1111};
        play("rr req1", 2'b10);
        cycle("rr done1", 2'b00, 1'b1, 1'b1, 4'b0000);
        cycle("rr idle1", 2'b00, 1'b0, 1'b0, 4'b0000);
        cycle("rr req0 again", 2'b01, 1'b1, 1'b0, 4'b0001);

        // len 0 means 16 steps of binary count.
        rst = 1'b1; req0 = 1'b0; req1 = 1'b1; mode1 = 2'd3; len1 = 4'd0;
        cycle("cnt reset", 2'b00, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        play("cnt16", 2'b10);
        cycle("cnt16 done", 2'b00, 1'b1, 1'b1, 4'b0000);
        req1 = 1'b0;
        cycle("cnt16 idle", 2'b00, 1'b0, 1'b0, 4'b0000);

        // Abort: req0 drops two cycles into step 1 while req1 waits.
        rst = 1'b1; req0 = 1'b1; mode0 = 2'd0; len0 = 4'd4;
        req1 = 1'b1; mode1 = 2'd2; len1 = 4'd2;
        cycle("abort reset", 2'b00, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        exp_q = '{4'b0001};
        play("abort req0", 2'b01);
        cycle("abort s1 c0", 2'b01, 1'b1, 1'b0, 4'b0010);
        cycle("abort s1 c1", 2'b01, 1'b1, 1'b0, 4'b0010);
        req0 = 1'b0;
        cycle("abort idle", 2'b00, 1'b0, 1'b0, 4'b0000);
        cycle("abort req1 gnt", 2'b10, 1'b1, 1'b0, 4'b1111);

        // Reset mid-run at frame 2, then a fresh run from frame 0.
        rst = 1'b1; req1 = 1'b0; req0 = 1'b1; mode0 = 2'd0; len0 = 4'd4;
        cycle("midrst reset", 2'b00, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        exp_q = '{4'b0001, 4'b0010};
        play("midrst run", 2'b01);
        cycle("midrst f2", 2'b01, 1'b1, 1'b0, 4'b0100);
        rst = 1'b1;
        cycle("midrst hit", 2'b00, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        exp_q = '{4'b0001};
        play("midrst restart", 2'b01);
        cycle("midrst f1", 2'b01, 1'b1, 1'b0, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_seq_arbiter.md
Name: led_seq_arbiter

Overview:
- Shares the 4-lamp LED bank between two pattern requesters on the 48 MHz board clock.
- A round-robin arbiter grants the bank to one requester at a time.
- A tick-driven sequencer then plays the granted pattern for the requested number of steps and releases the bank.
- Sits between user-logic sources (e.g. buzzer alert, status heartbeat) and the board LED pins, replacing free-running per-demo LED logic.

Parameters:
- STEP_DIV, 24_000_000: clk cycles per pattern step (0.5 s at 48 MHz); must be >= 2.
- CNT_W, 32: width of the step prescaler counter.

Ports:
- clk  in  1  board clock, 48 MHz
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 bank request (level)
- mode0  in  2  requester 0 pattern select
- len0  in  4  requester 0 step count (0 means 16)
- req1  in  1  requester 1 bank request (level)
- mode1  in  2  requester 1 pattern select
- len1  in  4  requester 1 step count (0 means 16)
- gnt  out  2  one-hot grant; gnt[i] high while requester i owns the bank
- busy  out  1  high in RUN and DONE
- done  out  1  1-cycle pulse on normal completion
- led  out  4  LED drive, active-high

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high.
- Reset values: state=IDLE, gnt=00, busy=0, done=0, led=0000, prescaler=0, step count=0, last-grant pointer=1 (so req0 wins the first tie).
- States: IDLE, RUN, DONE.
- IDLE: led=0000.
  - If exactly one req is high, grant it.
  - If both are high, grant the one not equal to the last-grant pointer.
  - On grant: latch that requester's mode and len (len 0 becomes 16), update the pointer, clear prescaler and step count, go to RUN.
- Latency: req seen high at edge n gives gnt/busy high and led = frame 0 of the pattern from edge n+1.
- RUN:
  - Prescaler counts 0..STEP_DIV-1. tick is asserted when prescaler==STEP_DIV-1; the prescaler then wraps to 0.
  - On each tick, step count increments and led advances to the next frame.
  - When a tick would make step count == latched len, go to DONE instead. Frame 0 plus len-1 advances are shown, each for STEP_DIV cycles.
- Patterns, frame 0 first, wrapping cyclically:
  - mode 0: single walk 0001, 0010, 0100, 1000.
  - mode 1: double walk 1100, 1001, 0011, 0110.
  - mode 2: blink 1111, 0000.
  - mode 3: binary count 0000 through 1111.
- DONE: lasts exactly one cycle. done=1, gnt=00, busy=1, led=0000. Then go to IDLE.
- Abort: if the granted req drops during RUN, go directly to IDLE next cycle. gnt=00, led=0000, no done pulse, pointer keeps the aborted requester.
- Request changes:
  - mode/len changes during RUN are ignored.
  - A req from the other requester during RUN waits; it is served on the first IDLE cycle after DONE/abort.
- Back-to-back: both requesters holding req alternate ownership. There is one IDLE cycle between DONE and the next RUN.
- Reset asserted in any state returns everything to reset values on the next edge, including mid-RUN.
- Width rules: step count is 5 bits so that len=16 is representable. Prescaler compare uses CNT_W bits.

Decomposition:
- Package led_seq_pkg holds:
  - state encoding constants (IDLE, RUN, DONE);
  - mode constants (MODE_WALK=0, MODE_DOUBLE=1, MODE_BLINK=2, MODE_COUNT=3);
  - the frame lookup function (mode, frame index) -> 4-bit pattern.
- One sub-module is natural: led_step_tick, the prescaler with a clear input, a tick output and the STEP_DIV parameter.
- Arbiter and FSM stay in the top.

Test Plan (STEP_DIV=4 for simulation):
1. Reset held 3 cycles with req0=1 -> gnt=00, led=0000, busy=0 throughout; gnt=01 one edge after rst falls.
2. req0=1, mode0=1, len0=4 -> led 1100, 1001, 0011, 0110, each for 4 cycles; then done=1 for one cycle with led=0000, gnt=00; then IDLE.
3. req0 and req1 both high from reset, mode0=0/len0=2, mode1=2/len1=3 -> sequence: req0 runs (0001, 0010), req1 runs (1111, 0000, 1111), then req0 again. Exactly one IDLE cycle between runs; done pulses once per run.
4. len1=0, mode1=3 -> 16 frames 0000..1111, each 4 cycles, before done.
5. Abort: drop req0 two cycles into step 1 -> next edge state=IDLE, led=0000, gnt=00, done never pulses; pending req1 is granted the following edge.
6. rst asserted mid-RUN at frame 2 -> next edge all outputs at reset values; a fresh req0 restarts at frame 0 with a full STEP_DIV dwell.
